// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg
// Constants shared by the fetch stage: datapath width, the RV32I opcodes
// that the pre-decoder recognises, the fetch FSM state encoding and a
// small PC helper.
package instr_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_WAIT_IC   = 2'd1,
    ST_WAIT_JALR = 2'd2
  } fetch_state_e;

  // Sequential successor; 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
  function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if
// Bundles every bus the fetch stage talks to:
//   icache    : if2ic_valid/if2ic_addr out, ic2if_ready/ic2if_instr in
//   predictor : if2pred_pc out, pred2if_result in (combinational lookup)
//   decoder   : if2dec_valid/instr/pc/pred_jump out, dec_full in
//   redirects : jalr_valid/jalr_target, rob_flush/rob_new_pc in
// master = fetch stage, slave = its environment.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic            if2ic_valid;
  logic [XLEN-1:0] if2ic_addr;
  logic            ic2if_ready;
  logic [XLEN-1:0] ic2if_instr;
  logic [XLEN-1:0] if2pred_pc;
  logic            pred2if_result;
  logic            dec_full;
  logic            if2dec_valid;
  logic [XLEN-1:0] if2dec_instr;
  logic [XLEN-1:0] if2dec_pc;
  logic            if2dec_pred_jump;
  logic            jalr_valid;
  logic [XLEN-1:0] jalr_target;
  logic            rob_flush;
  logic [XLEN-1:0] rob_new_pc;

  modport master (
    output if2ic_valid, if2ic_addr, if2pred_pc,
           if2dec_valid, if2dec_instr, if2dec_pc, if2dec_pred_jump,
    input  ic2if_ready, ic2if_instr, pred2if_result, dec_full,
           jalr_valid, jalr_target, rob_flush, rob_new_pc
  );

  modport slave (
    input  if2ic_valid, if2ic_addr, if2pred_pc,
           if2dec_valid, if2dec_instr, if2dec_pc, if2dec_pred_jump,
    output ic2if_ready, ic2if_instr, pred2if_result, dec_full,
           jalr_valid, jalr_target, rob_flush, rob_new_pc
  );

endinterface

// File: rtl/if_predecode.sv
// if_predecode
// Combinational pre-decoder for control-flow instructions.
//   instr   in  32  instruction word
//   pc      in  32  its address
//   is_jal  out  1  opcode is JAL
//   is_br   out  1  opcode is a conditional branch
//   is_jalr out  1  opcode is JALR
//   target  out 32  pc + immJ for JAL, pc + immB otherwise
module if_predecode
  import instr_fetch_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  output logic            is_jal,
  output logic            is_br,
  output logic            is_jalr,
  output logic [XLEN-1:0] target
);

  logic [6:0]      opcode;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_b;

  assign opcode = instr[6:0];

  // Both immediates are scrambled in the encoding and sign-extended from bit 31.
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

  assign is_jal  = (opcode == OP_JAL);
  assign is_br   = (opcode == OP_BRANCH);
  assign is_jalr = (opcode == OP_JALR);
  assign target  = pc + (is_jal ? imm_j : imm_b);

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
// Fetch stage: holds the PC, requests words from the icache, pre-decodes
// control flow (JAL, predicted branches, JALR stall) and hands each word to
// the decoder one cycle after the icache returns it.
//   clk_in  in  clock
//   rst_in  in  asynchronous active-high reset
//   rdy_in  in  global enable; low freezes all state
//   bus     master side of instr_fetch_if (icache, predictor, decoder,
//           JALR resolution and ROB flush)
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  instr_fetch_if.master bus
);

  fetch_state_e    state_reg;
  logic [XLEN-1:0] pc_reg;
  logic            ic_valid_reg;
  logic [XLEN-1:0] ic_addr_reg;
  logic            dec_valid_reg;
  logic [XLEN-1:0] dec_instr_reg;
  logic [XLEN-1:0] dec_pc_reg;
  logic            dec_pred_reg;

  logic            is_jal;
  logic            is_br;
  logic            is_jalr;
  logic [XLEN-1:0] br_target;
  logic            pred_jump_next;
  logic [XLEN-1:0] pc_next;

  if_predecode u_predecode (
    .instr   (bus.ic2if_instr),
    .pc      (pc_reg),
    .is_jal  (is_jal),
    .is_br   (is_br),
    .is_jalr (is_jalr),
    .target  (br_target)
  );

  // The PC only moves while a word is outstanding, so it is always the
  // address of the word the icache is returning.
  assign bus.if2pred_pc = pc_reg;

  assign pred_jump_next = is_jal | (is_br & bus.pred2if_result);
  assign pc_next        = pred_jump_next ? br_target : seq_pc(pc_reg);

  assign bus.if2ic_valid      = ic_valid_reg;
  assign bus.if2ic_addr       = ic_addr_reg;
  assign bus.if2dec_valid     = dec_valid_reg;
  assign bus.if2dec_instr     = dec_instr_reg;
  assign bus.if2dec_pc        = dec_pc_reg;
  assign bus.if2dec_pred_jump = dec_pred_reg;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg     <= ST_FETCH;
      pc_reg        <= RESET_PC;
      ic_valid_reg  <= 1'b0;
      ic_addr_reg   <= '0;
      dec_valid_reg <= 1'b0;
      dec_instr_reg <= '0;
      dec_pc_reg    <= '0;
      dec_pred_reg  <= 1'b0;
    end else begin
      // Delivery is a single-cycle pulse; also keeps it low while frozen.
      dec_valid_reg <= 1'b0;
      if (rdy_in) begin
        if (bus.rob_flush) begin
          // Dropping if2ic_valid aborts any outstanding icache request and
          // the ready that may coincide with the flush is ignored.
          state_reg    <= ST_FETCH;
          pc_reg       <= bus.rob_new_pc;
          ic_valid_reg <= 1'b0;
        end else begin
          case (state_reg)
            ST_FETCH: begin
              if (!bus.dec_full) begin
                ic_valid_reg <= 1'b1;
                ic_addr_reg  <= pc_reg;
                state_reg    <= ST_WAIT_IC;
              end
            end
            ST_WAIT_IC: begin
              if (bus.ic2if_ready) begin
                ic_valid_reg  <= 1'b0;
                dec_valid_reg <= 1'b1;
                dec_instr_reg <= bus.ic2if_instr;
                dec_pc_reg    <= pc_reg;
                dec_pred_reg  <= pred_jump_next;
                if (is_jalr) begin
                  state_reg <= ST_WAIT_JALR;
                end else begin
                  pc_reg    <= pc_next;
                  state_reg <= ST_FETCH;
                end
              end
            end
            ST_WAIT_JALR: begin
              if (bus.jalr_valid) begin
                pc_reg    <= bus.jalr_target;
                state_reg <= ST_FETCH;
              end
            end
            default: state_reg <= ST_FETCH;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
// Directed bench for instr_fetch: a table of single-instruction fetches
// (start pc, word, predictor answer, expected delivery and next request
// address) plus hand-written sequences for JALR, flush and stall cases.
module tb_instr_fetch;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
    logic        exp_pj;
    logic [31:0] exp_next;
  } vec_t;

  localparam logic [31:0] I_ADDI   = 32'h0010_0093; // addi x1,x0,1
  localparam logic [31:0] I_JAL16  = 32'h0100_006F; // jal x0,+16
  localparam logic [31:0] I_JALM4  = 32'hFFDF_F06F; // jal x0,-4
  localparam logic [31:0] I_BEQM8  = 32'hFE00_0CE3; // beq x0,x0,-8
  localparam logic [31:0] I_BNE12  = 32'h0000_1663; // bne x0,x0,+12
  localparam logic [31:0] I_JALR   = 32'h0000_8067; // jalr x0,0(x1)

  vec_t vecs[9];
  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (bus.if2ic_valid !== 1'b1 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    check({nm, "_req_seen"}, {31'd0, bus.if2ic_valid}, 32'd1);
  endtask

  task automatic redirect(input logic [31:0] new_pc);
    @(negedge clk_in);
    bus.rob_flush  = 1'b1;
    bus.rob_new_pc = new_pc;
    @(negedge clk_in);
    bus.rob_flush  = 1'b0;
  endtask

  // Return a word in the current (negedge-aligned) cycle, then step one cycle.
  task automatic ic_return(input logic [31:0] instr, input logic pred);
    bus.ic2if_ready    = 1'b1;
    bus.ic2if_instr    = instr;
    bus.pred2if_result = pred;
    @(negedge clk_in);
    bus.ic2if_ready    = 1'b0;
    bus.pred2if_result = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"addi_0",     32'h0000_0000, I_ADDI,  1'b0, 1'b0, 32'h0000_0004};
    vecs[1] = '{"jal_p16",    32'h0000_0008, I_JAL16, 1'b0, 1'b1, 32'h0000_0018};
    vecs[2] = '{"beq_taken",  32'h0000_0020, I_BEQM8, 1'b1, 1'b1, 32'h0000_0018};
    vecs[3] = '{"beq_ntaken", 32'h0000_0020, I_BEQM8, 1'b0, 1'b0, 32'h0000_0024};
    vecs[4] = '{"bne_taken",  32'h0000_0050, I_BNE12, 1'b1, 1'b1, 32'h0000_005C};
    vecs[5] = '{"jal_m4",     32'h0000_1000, I_JALM4, 1'b0, 1'b1, 32'h0000_0FFC};
    vecs[6] = '{"jal_wrap",   32'hFFFF_FFF8, I_JAL16, 1'b1, 1'b1, 32'h0000_0008};
    vecs[7] = '{"addi_wrap",  32'hFFFF_FFFC, I_ADDI,  1'b1, 1'b0, 32'h0000_0000};
    vecs[8] = '{"jal_pred0",  32'h0000_0100, I_JAL16, 1'b0, 1'b1, 32'h0000_0110};

    rst_in = 1'b1;
    rdy_in = 1'b1;
    bus.ic2if_ready    = 1'b0;
    bus.ic2if_instr    = '0;
    bus.pred2if_result = 1'b0;
    bus.dec_full       = 1'b0;
    bus.jalr_valid     = 1'b0;
    bus.jalr_target    = '0;
    bus.rob_flush      = 1'b0;
    bus.rob_new_pc     = '0;

    // Reset state
    repeat (2) @(negedge clk_in);
    check("rst_ic_valid",  {31'd0, bus.if2ic_valid}, 32'd0);
    check("rst_ic_addr",   bus.if2ic_addr, 32'd0);
    check("rst_dec_valid", {31'd0, bus.if2dec_valid}, 32'd0);
    check("rst_dec_pc",    bus.if2dec_pc, 32'd0);
    rst_in = 1'b0;
    wait_req("rst");
    check("rst_first_addr", bus.if2ic_addr, 32'd0);
    $display("reset: first request addr=%h", bus.if2ic_addr);

    // Table-driven single fetches
    for (int i = 0; i < 9; i++) begin
      redirect(vecs[i].pc);
      check({vecs[i].name, "_flush_idle"}, {31'd0, bus.if2ic_valid}, 32'd0);
      wait_req(vecs[i].name);
      check({vecs[i].name, "_addr"}, bus.if2ic_addr, vecs[i].pc);
      @(negedge clk_in);
      check({vecs[i].name, "_addr_hold"}, bus.if2ic_addr, vecs[i].pc);
      check({vecs[i].name, "_pred_pc"}, bus.if2pred_pc, vecs[i].pc);
      ic_return(vecs[i].instr, vecs[i].pred);
      check({vecs[i].name, "_dec_valid"}, {31'd0, bus.if2dec_valid}, 32'd1);
      check({vecs[i].name, "_dec_pc"}, bus.if2dec_pc, vecs[i].pc);
      check({vecs[i].name, "_dec_instr"}, bus.if2dec_instr, vecs[i].instr);
      check({vecs[i].name, "_dec_pj"}, {31'd0, bus.if2dec_pred_jump}, {31'd0, vecs[i].exp_pj});
      @(negedge clk_in);
      check({vecs[i].name, "_dec_pulse"}, {31'd0, bus.if2dec_valid}, 32'd0);
      wait_req({vecs[i].name, "_next"});
      check({vecs[i].name, "_next_addr"}, bus.if2ic_addr, vecs[i].exp_next);
      $display("vec %s pc=%h instr=%h pj=%b next=%h",
               vecs[i].name, vecs[i].pc, vecs[i].instr, bus.if2dec_pred_jump, bus.if2ic_addr);
    end

    // JALR: stall until the target resolves
    redirect(32'h0000_0028);
    wait_req("jalr");
    ic_return(I_JALR, 1'b1);
    check("jalr_dec_valid", {31'd0, bus.if2dec_valid}, 32'd1);
    check("jalr_dec_pc",    bus.if2dec_pc, 32'h0000_0028);
    check("jalr_dec_pj",    {31'd0, bus.if2dec_pred_jump}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      check("jalr_stall", {31'd0, bus.if2ic_valid}, 32'd0);
    end
    bus.jalr_valid  = 1'b1;
    bus.jalr_target = 32'h0000_0100;
    @(negedge clk_in);
    bus.jalr_valid  = 1'b0;
    wait_req("jalr_tgt");
    check("jalr_tgt_addr", bus.if2ic_addr, 32'h0000_0100);
    $display("jalr: resolved target request addr=%h", bus.if2ic_addr);

    // JALR resolution coinciding with a flush: flush wins
    ic_return(I_JALR, 1'b0);
    bus.jalr_valid  = 1'b1;
    bus.jalr_target = 32'h0000_0300;
    bus.rob_flush   = 1'b1;
    bus.rob_new_pc  = 32'h0000_0400;
    @(negedge clk_in);
    bus.jalr_valid  = 1'b0;
    bus.rob_flush   = 1'b0;
    wait_req("jalr_flush");
    check("jalr_flush_addr", bus.if2ic_addr, 32'h0000_0400);
    $display("jalr+flush: request addr=%h", bus.if2ic_addr);

    // Flush in the same cycle as ic2if_ready: word discarded
    redirect(32'h0000_0040);
    wait_req("flush_rdy");
    bus.rob_flush  = 1'b1;
    bus.rob_new_pc = 32'h0000_0200;
    ic_return(I_ADDI, 1'b0);
    bus.rob_flush  = 1'b0;
    check("flush_rdy_no_dec", {31'd0, bus.if2dec_valid}, 32'd0);
    check("flush_rdy_abort",  {31'd0, bus.if2ic_valid}, 32'd0);
    wait_req("flush_rdy_next");
    check("flush_rdy_addr", bus.if2ic_addr, 32'h0000_0200);
    ic_return(I_ADDI, 1'b0);
    check("flush_rdy_dec_pc", bus.if2dec_pc, 32'h0000_0200);
    $display("flush+ready: redirected request addr=200 delivered pc=%h", bus.if2dec_pc);

    // dec_full held in FETCH
    @(negedge clk_in);
    bus.dec_full = 1'b1;
    redirect(32'h0000_0080);
    for (int k = 0; k < 5; k++) begin
      check("full_idle", {31'd0, bus.if2ic_valid}, 32'd0);
      @(negedge clk_in);
    end
    bus.dec_full = 1'b0;
    @(negedge clk_in);
    check("full_release_valid", {31'd0, bus.if2ic_valid}, 32'd1);
    check("full_release_addr",  bus.if2ic_addr, 32'h0000_0080);

    // rdy_in low mid-WAIT_IC: even a flush must not move anything
    rdy_in         = 1'b0;
    bus.rob_flush  = 1'b1;
    bus.rob_new_pc = 32'h0000_0500;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check("frz_valid",   {31'd0, bus.if2ic_valid}, 32'd1);
      check("frz_addr",    bus.if2ic_addr, 32'h0000_0080);
      check("frz_pred_pc", bus.if2pred_pc, 32'h0000_0080);
    end
    bus.rob_flush = 1'b0;
    rdy_in        = 1'b1;

    // dec_full rising while waiting: in-flight word still delivers
    bus.dec_full = 1'b1;
    @(negedge clk_in);
    check("full_wait_valid", {31'd0, bus.if2ic_valid}, 32'd1);
    ic_return(I_ADDI, 1'b0);
    check("full_wait_dec",    {31'd0, bus.if2dec_valid}, 32'd1);
    check("full_wait_dec_pc", bus.if2dec_pc, 32'h0000_0080);
    @(negedge clk_in);
    check("full_wait_hold", {31'd0, bus.if2ic_valid}, 32'd0);
    bus.dec_full = 1'b0;
    @(negedge clk_in);
    check("full_wait_next", bus.if2ic_addr, 32'h0000_0084);
    check("full_wait_next_v", {31'd0, bus.if2ic_valid}, 32'd1);
    $display("stall: frozen pc=80 delivered, next request addr=%h", bus.if2ic_addr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
